clkdiv_multi: RTL

Parametrised multi-channel programmable clock-enable generator, successor to the fixed power-of-two divider. Each of NCH channels divides the system clock by a run-time programmable integer (not only powers of two) and produces a one-cycle `tick` enable plus a registered square-wave `clk_out`. Divisor changes are glitch-free: a new divisor takes effect only at a period boundary. The block sits beside the display/scan and ROM-stepping logic, which consume `tick` as clock enables.

---
 rtl/clkdiv_multi.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NCH independent run-time programmable clock-enable generators.
// Each channel counts 0..D and then emits a one-cycle tick. clk_out toggles on
// every tick. New divisors are staged in pend_div and are applied only at a
// period boundary, so consumers of tick never see a runt or stretched period.
module clkdiv_multi #(
   parameter int          NCH     = 4,
   parameter int          W       = 24,
   parameter int unsigned DIV_RST = 1,
   localparam int         CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           clr_n,
   input  logic [NCH-1:0] ch_en,
   input  logic           sync,
   input  logic           wr_en,
   input  logic [CW-1:0]  wr_ch,
   input  logic [W-1:0]   wr_div,
   output logic           wr_ack,
   output logic           wr_err,
   output logic [NCH-1:0] tick,
   output logic [NCH-1:0] clk_out
);

   localparam logic [W-1:0]  DIV_RST_W = W'(DIV_RST);
   localparam logic [CW:0]   NCH_W     = (CW + 1)'(NCH);

   // wr_ch can encode more values than there are channels when NCH is not a
   // power of two; those writes are rejected without touching any channel.
   logic wr_in_range;
   logic wr_valid;

   assign wr_in_range = ({1'b0, wr_ch} < NCH_W);
   assign wr_valid    = wr_en & wr_in_range;

   logic wr_ack_q, wr_ack_d;
   logic wr_err_q, wr_err_d;

   // Write handshake: accept or reject every strobe, one per cycle, no stall.
   always_comb begin
      wr_ack_d = wr_valid;
      wr_err_d = wr_en & ~wr_in_range;
   end

   // Handshake pulse registers.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         wr_ack_q <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         // NOTE: state is always updated with <= so every register samples the
         // pre-edge values, independent of the order of statements or blocks.
         wr_ack_q <= wr_ack_d;
         wr_err_q <= wr_err_d;
      end
   end

   assign wr_ack = wr_ack_q;
   assign wr_err = wr_err_q;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [W-1:0] cnt_q,  cnt_d;
      logic [W-1:0] cur_q,  cur_d;
      logic [W-1:0] pdiv_q, pdiv_d;
      logic         pend_q, pend_d;
      logic         tick_q, tick_d;
      logic         clko_q, clko_d;
      logic         wr_hit;
      logic         at_tc;

      assign wr_hit = wr_valid & (wr_ch == CW'(g));
      assign at_tc  = (cnt_q == cur_q);

      // Channel next state: sync/disable park the channel, otherwise count.
      always_comb begin
         // NOTE: every output of this block gets a default first, so no path
         // leaves a signal unassigned and no latch is inferred.
         cnt_d  = cnt_q;
         cur_d  = cur_q;
         pdiv_d = pdiv_q;
         pend_d = pend_q;
         tick_d = 1'b0;
         clko_d = clko_q;

         if (sync || !ch_en[g]) begin
            // Parked or restarting: no period is in flight, so any staged
            // divisor and any new write can go straight into cur_div.
            cnt_d  = '0;
            clko_d = 1'b0;
            if (pend_q) begin
               cur_d  = pdiv_q;
               pend_d = 1'b0;
            end
            if (wr_hit) begin
               cur_d = wr_div;
            end
         end else begin
            if (at_tc) begin
               cnt_d  = '0;
               tick_d = 1'b1;
               clko_d = ~clko_q;
               if (pend_q) begin
                  cur_d  = pdiv_q;
                  pend_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + W'(1);
            end
            // A write on a running channel is staged; on a terminal-count edge
            // it lands after the old staged value has been consumed above.
            if (wr_hit) begin
               pdiv_d = wr_div;
               pend_d = 1'b1;
            end
         end
      end

      // Channel state registers.
      always_ff @(posedge clk or negedge clr_n) begin
         if (!clr_n) begin
            cnt_q  <= '0;
            cur_q  <= DIV_RST_W;
            pdiv_q <= '0;
            pend_q <= 1'b0;
            tick_q <= 1'b0;
            clko_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            cur_q  <= cur_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            tick_q <= tick_d;
            clko_q <= clko_d;
         end
      end

      assign tick[g]    = tick_q;
      assign clk_out[g] = clko_q;
   end

endmodule
